// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and opcode constants (also used by the control decoder).
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_RETRY,
    S_HOLD,
    S_HALT
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

endpackage

// File: rtl/fetch_next_pc_calc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential.
module next_pc_calc (
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_field,
  input  logic        branch_select,
  input  logic        jump_select,
  input  logic        alu_zero,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;

  // Targets wrap mod 2^32; branch offset is sign-extended word offset.
  always_comb begin
    jump_target   = {pc_plus4[31:28], instr_field, 2'b00};
    branch_target = pc_plus4 + {{14{instr_field[15]}}, instr_field[15:0], 2'b00};
    next_pc       = pc_plus4;
    if (jump_select) begin
      next_pc = jump_target;
    end else if (branch_select && alu_zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, req/ack fetch with timeout retry,
// instruction hold until retire, halt on sentinel word.
// Optional feature macro: FETCH_PERF_EN (adds retired_count / wait_count).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_select,
  input  logic        jump_select,
  input  logic        alu_zero,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
`ifdef FETCH_PERF_EN
  output logic [31:0] retired_count,
  output logic [31:0] wait_count,
`endif
  output logic        halt
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]  next_pc;

  next_pc_calc u_next_pc (
    .pc_plus4      (pc_plus4),
    .instr_field   (instr_q[25:0]),
    .branch_select (branch_select),
    .jump_select   (jump_select),
    .alu_zero      (alu_zero),
    .next_pc       (next_pc)
  );

  // State, PC, held instruction and timeout counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: ack wins over timeout in the final S_REQ cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          cnt_d   = '0;
          state_d = (imem_rdata == HALT_WORD) ? S_HALT : S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_RETRY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RETRY: state_d = S_REQ;
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = S_REQ;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_REQ;
    endcase
  end

  // Outputs decoded from registered state; req is also gated by reset so it drops at once.
  always_comb begin
    imem_req    = (state_q == S_REQ) && !reset;
    imem_addr   = pc_q;
    pc_out      = pc_q;
    pc_plus4    = pc_q + 32'd4;
    instruction = instr_q;
    instr_valid = (state_q == S_HOLD);
    halt        = (state_q == S_HALT);
  end

`ifdef FETCH_PERF_EN
  logic [31:0] ret_q, ret_d;
  logic [31:0] wait_q, wait_d;

  // Performance counters; naturally frozen in S_HALT since neither condition holds there.
  always_comb begin
    ret_d  = ret_q;
    wait_d = wait_q;
    if (state_q == S_HOLD && instr_ready) begin
      ret_d = ret_q + 32'd1;
    end
    if ((state_q == S_REQ || state_q == S_RETRY) && !imem_ack) begin
      wait_d = wait_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_q  <= '0;
      wait_q <= '0;
    end else begin
      ret_q  <= ret_d;
      wait_q <= wait_d;
    end
  end

  assign retired_count = ret_q;
  assign wait_count    = wait_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit plus hand sequences for
// timeout/retry, halt and mid-fetch reset.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned TMO = 16;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_select;
  logic        jump_select;
  logic        alu_zero;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        halt;
`ifdef FETCH_PERF_EN
  logic [31:0] retired_count;
  logic [31:0] wait_count;
`endif

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .HALT_WORD   (HALTW),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_select (branch_select),
    .jump_select   (jump_select),
    .alu_zero      (alu_zero),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
`ifdef FETCH_PERF_EN
    .retired_count (retired_count),
    .wait_count    (wait_count),
`endif
    .halt          (halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        br;
    logic        jmp;
    logic        zero;
    int unsigned ack_dly;
    int unsigned stall;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[14];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned sum_dly;
  int unsigned hi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int unsigned k;
    k = 0;
    while (!imem_req && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    wait_req();
    chk({tag, "_addr"}, imem_addr, v.addr);
    for (int unsigned d = 0; d < v.ack_dly; d++) begin
      @(negedge clk);
      chk({tag, "_addr_stable"}, {imem_req, imem_addr[30:0]}, {1'b1, v.addr[30:0]});
    end
    imem_ack   = 1'b1;
    imem_rdata = v.word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk({tag, "_valid"}, {30'd0, instr_valid, imem_req}, 32'd2);
    chk({tag, "_instr"}, instruction, v.word);
    chk({tag, "_pc"}, pc_out, v.addr);
    chk({tag, "_pc4"}, pc_plus4, v.addr + 32'd4);
    // Flags present while not ready must not influence the next PC.
    jump_select   = 1'b1;
    branch_select = 1'b1;
    alu_zero      = 1'b1;
    for (int unsigned s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {29'd0, instr_valid, imem_req, halt}, 32'd4);
      chk({tag, "_hold_instr"}, instruction, v.word);
      chk({tag, "_hold_pc"}, pc_out, v.addr);
    end
    branch_select = v.br;
    jump_select   = v.jmp;
    alu_zero      = v.zero;
    instr_ready   = 1'b1;
    @(negedge clk);
    instr_ready   = 1'b0;
    branch_select = 1'b0;
    jump_select   = 1'b0;
    alu_zero      = 1'b0;
    chk({tag, "_retired"}, {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] w_rt, w_lw, w_sw, w_beq_m2, w_beq_m3, w_j40, w_jall;
    w_rt     = {OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    w_lw     = {OP_LW, 5'd1, 5'd2, 16'h0004};
    w_sw     = {OP_SW, 5'd1, 5'd2, 16'h0008};
    w_beq_m2 = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};
    w_beq_m3 = {OP_BEQ, 5'd1, 5'd2, 16'hFFFD};
    w_j40    = {OP_J, 26'h40};
    w_jall   = {OP_J, 26'h3FF_FFFF};

    //                word      br    jmp   zero dly stall addr
    vecs[0]  = '{w_beq_m2, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0000_0000}; // 4-8 wraps
    vecs[1]  = '{w_rt,     1'b0, 1'b0, 1'b0, 0, 0, 32'hFFFF_FFFC}; // +4 wraps to 0
    vecs[2]  = '{w_lw,     1'b0, 1'b0, 1'b0, 0, 5, 32'h0000_0000};
    vecs[3]  = '{w_sw,     1'b0, 1'b0, 1'b0, 2, 0, 32'h0000_0004};
    vecs[4]  = '{w_rt,     1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0008};
    vecs[5]  = '{w_rt,     1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_000C};
    vecs[6]  = '{w_beq_m2, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0000_0010}; // -> 0x0C
    vecs[7]  = '{w_rt,     1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_000C};
    vecs[8]  = '{w_beq_m2, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0000_0010}; // not taken -> 0x14
    vecs[9]  = '{w_beq_m2, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0000_0014}; // no select -> 0x18
    vecs[10] = '{w_beq_m3, 1'b1, 1'b0, 1'b1, 0, 1, 32'h0000_0018}; // 0x1C-12 -> 0x10
    vecs[11] = '{w_j40,    1'b0, 1'b1, 1'b0, 1, 0, 32'h0000_0010}; // -> 0x100
    vecs[12] = '{w_jall,   1'b1, 1'b1, 1'b1, 0, 0, 32'h0000_0100}; // jump wins -> 0x0FFFFFFC
    vecs[13] = '{w_rt,     1'b0, 1'b0, 1'b0, 0, 0, 32'h0FFF_FFFC}; // -> 0x10000000

    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    instr_ready = 1'b0;
    branch_select = 1'b0;
    jump_select = 1'b0;
    alu_zero = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {29'd0, imem_req, instr_valid, halt}, 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
`ifdef FETCH_PERF_EN
    chk("rst_perf", retired_count | wait_count, 32'h0);
`endif
    reset = 1'b0;
    #1;
    chk("rel_req", {31'd0, imem_req}, 32'd1);

    sum_dly = 0;
    for (int i = 0; i < 14; i++) begin
      run_vec(i, vecs[i]);
      sum_dly += vecs[i].ack_dly;
    end
`ifdef FETCH_PERF_EN
    chk("perf_retired", retired_count, 32'd14);
    chk("perf_wait", wait_count, sum_dly);
`endif

    // Timeout: req held ACK_TIMEOUT cycles, low one cycle, re-issued at same address.
    hi = 0;
    while (imem_req && hi < 40) begin
      chk("tmo_addr", imem_addr, 32'h1000_0000);
      hi++;
      @(negedge clk);
    end
    chk("tmo_len", hi, TMO);
    chk("retry_low", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1;                 // ignored in S_RETRY
    imem_rdata = w_rt;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("retry_back", {30'd0, imem_req, instr_valid}, 32'd2);
    chk("retry_addr", imem_addr, 32'h1000_0000);

    // Reset mid-S_REQ abandons the request immediately.
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", pc_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_rel", {31'd0, imem_req}, 32'd1);

    // Halt on sentinel fetched at address 0 after two wait cycles.
    repeat (2) @(negedge clk);
    chk("halt_addr", imem_addr, 32'h0);
    imem_ack = 1'b1;
    imem_rdata = HALTW;
    @(negedge clk);
    chk("halt_state", {29'd0, halt, instr_valid, imem_req}, 32'd4);
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("halt_stuck", {29'd0, halt, instr_valid, imem_req}, 32'd4);
    end
    imem_ack = 1'b0;
    instr_ready = 1'b0;
`ifdef FETCH_PERF_EN
    chk("halt_retired", retired_count, 32'd0);
    chk("halt_wait", wait_count, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
